page_req_arb: RTL
=================

# page_req_arb

Round-robin front end for the page allocation map. Accepts alloc / free / stat / free-all requests from up to NCLIENT independent requesters, serialises them onto the map's single-command port, and waits for the map's `done` handshake. It returns the resulting page number or status bit to the requester that issued the command. It sits directly upstream of the page allocation map, and its map-side ports connect one-to-one to the map's command inputs.

## Interface
- NCLIENT, 4: number of requesters, 2..8.
- PGBITS, 15: page number width; must equal the map's page number width.
- clk  in  1: clock; all logic on the rising edge.
- rst  in  1: synchronous, active-high reset; shared with the map.
- req  in  NCLIENT: per-client request; held until that client's ack.
- cmd  in  2*NCLIENT: per-client command. 00 alloc, 01 free, 10 stat, 11 freeall.
- pageno_i  in  PGBITS*NCLIENT: per-client page operand for free and stat.
- val_i  in  2*NCLIENT: per-client stat operand, passed through to the map.
- ack  out  NCLIENT: one-cycle completion pulse.
- pageno_o  out  PGBITS: result; valid only in the ack cycle.
- err  out  1: error flag; valid only in the ack cycle.
- busy  out  1: high from grant through ack, and during INIT.
- pam_alloc, pam_free, pam_stat, pam_freeall  out  1 each: single-cycle command strobes to the map.
- pam_pageno  out  PGBITS; pam_val  out  2: operands driven to the map.
- pam_result  in  PGBITS: the map's page number output.
- pam_done  in  1: the map's done flag.

## Operation
- States:
  - INIT: after rst, wait for pam_done=1 (the map's own clear pass), then go to IDLE.
  - IDLE: if any req is set, grant one client by round robin. Latch its cmd, pageno_i and val_i, then go to ISSUE.
  - ISSUE: drive exactly one strobe for one cycle, then go to WLO.
  - WLO: wait for pam_done=0.
  - WHI: wait for pam_done=1, capture pam_result, then go to RESP.
  - RESP: pulse ack[grant], drive pageno_o and err, then go to IDLE.
- Round robin: the search starts at (last_grant+1) mod NCLIENT. After rst, last_grant = NCLIENT-1, so client 0 has first priority.
- The latched operands are frozen from grant to ack. Changes to req, cmd or pageno_i from the granted client are ignored until its ack.
- alloc: the map returns page 0 on exhaustion. Page 0 is permanently reserved, so pam_result==0 gives err=1 and pageno_o=0.
- free: pageno_o = the freed page number. err=0 unless the optional check below is enabled.
- stat: pageno_o = zero-extended map bit; err=0.
- freeall: pageno_o=0, err=0. All other requests stall behind it as normal.
- Strobes are never asserted outside ISSUE. At most one strobe is asserted per command.
- rst at any time: return to INIT and drop any in-flight command without an ack. Requesters must re-issue.

## Timing
- Reset values: ack=0, pageno_o=0, err=0, busy=1 (INIT), all strobes=0, pam_pageno=0, pam_val=0.
- Minimum latency from req sampled in IDLE to ack is 1 (IDLE) + 1 (ISSUE) + the map's command time + 1 (RESP).
  - An uncontended alloc that hits the current word completes 7 cycles after req is sampled.
- Back-to-back commands: IDLE can grant on the cycle after RESP, giving one idle cycle between commands.
- A req rising in the ack cycle of the same client is treated as a new request.

## Configuration
- PAGE_REQ_ARB_FREE_CHECK_EN defined:
  - A free is issued as pam_stat with pam_val=2'b00, which clears the bit and returns its prior value.
  - A prior value of 0 means a double free: err=1 on ack.
  - pam_free is never strobed.
- Undefined: free is issued on pam_free and err is always 0 for free.

## Structure
- Package page_req_pkg holds:
  - the cmd_t enum (CMD_ALLOC, CMD_FREE, CMD_STAT, CMD_FREEALL);
  - the state_t enum;
  - the default PGBITS.
- Sub-module rr_arbiter (NCLIENT): takes req and an advance pulse; returns a one-hot grant and an encoded index; holds the last_grant register.

## Test plan
- Reset, then single alloc from client 2 → ack[2] exactly once. The first alloc returns page 32, err=0. busy is low in the cycle after RESP.
- Clients 0, 1 and 3 assert alloc in the same cycle → grants in order 0, 1, 3. Returned pages are 32, 33, 34 and are distinct.
- Free page 33, then stat page 33 with val 2'b10 → stat pageno_o=0.
- Fill the map until the map returns 0 → err=1, pageno_o=0.
- With PAGE_REQ_ARB_FREE_CHECK_EN: free page 40 twice → the first free gives err=0, the second gives err=1. pam_free stays 0 throughout.
- rst asserted in WHI during an alloc → no ack; FSM passes through INIT. The client re-issues the alloc and gets ack with err=0.

Source files
------------

// File: rtl/page_req_arb_pkg.sv
// page_req_pkg: shared types and defaults for the page allocation map front end.
//   cmd_t   - requester command encoding (matches the 2-bit cmd field per client)
//   state_t - page_req_arb sequencing states, also exported on the debug port
//   PGBITS_DEFAULT / NCLIENT_DEFAULT - default widths
package page_req_pkg;

    localparam int PGBITS_DEFAULT  = 15;
    localparam int NCLIENT_DEFAULT = 4;

    typedef enum logic [1:0] {
        CMD_ALLOC   = 2'b00,
        CMD_FREE    = 2'b01,
        CMD_STAT    = 2'b10,
        CMD_FREEALL = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WLO   = 3'd3,
        ST_WHI   = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/page_req_arb_if.sv
// page_req_arb_if: requester-side bus of page_req_arb.
//   req      - per-client request level, held until that client's ack
//   cmd      - per-client 2-bit command (cmd_t encoding)
//   pageno_i - per-client page operand (free, stat)
//   val_i    - per-client 2-bit stat operand
//   ack      - per-client one-cycle completion pulse
//   pageno_o - result page / status bit, valid only in the ack cycle
//   err      - error flag, valid only in the ack cycle
//   busy     - arbiter is initialising or has a command in flight
// Handshake: a client raises req[i] with its operands stable and keeps them
// until it sees ack[i]; the ack cycle is the only cycle pageno_o/err mean
// anything. A req still high in the cycle after ack is a new request.
// Modports: master = requester side, slave = page_req_arb.
interface page_req_arb_if #(
    parameter int NCLIENT = page_req_pkg::NCLIENT_DEFAULT,
    parameter int PGBITS  = page_req_pkg::PGBITS_DEFAULT
);
    logic [NCLIENT-1:0]        req;
    logic [2*NCLIENT-1:0]      cmd;
    logic [PGBITS*NCLIENT-1:0] pageno_i;
    logic [2*NCLIENT-1:0]      val_i;
    logic [NCLIENT-1:0]        ack;
    logic [PGBITS-1:0]         pageno_o;
    logic                      err;
    logic                      busy;

    modport master (
        output req, cmd, pageno_i, val_i,
        input  ack, pageno_o, err, busy
    );

    modport slave (
        input  req, cmd, pageno_i, val_i,
        output ack, pageno_o, err, busy
    );
endinterface

// File: rtl/page_req_arb_rr_arbiter.sv
// rr_arbiter: round-robin request picker.
//   clk, rst  - clock, synchronous active-high reset
//   req       - request vector
//   advance   - accept the current pick; it becomes last_grant
//   grant     - one-hot pick (zero when no request)
//   grant_idx - encoded pick
//   any       - at least one request present
// The search starts one past last_grant; reset puts last_grant on the top
// client so client 0 is searched first.
module rr_arbiter #(
    parameter  int NCLIENT = 4,
    localparam int IDXW    = (NCLIENT > 1) ? $clog2(NCLIENT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCLIENT-1:0] req,
    input  logic               advance,
    output logic [NCLIENT-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               any
);
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] cand_idx;
    int              cand;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NCLIENT; i++) begin
            cand     = (int'(last_grant) + i) % NCLIENT;
            cand_idx = IDXW'(cand);
            if (!any && req[cand_idx]) begin
                any       = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant = any ? (NCLIENT'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDXW'(NCLIENT - 1);
        end else if (advance && any) begin
            last_grant <= grant_idx;
        end
    end
endmodule

// File: rtl/page_req_arb.sv
// page_req_arb: round-robin front end serialising client commands onto the
// page allocation map's single command port.
//   clk, rst     - clock, synchronous active-high reset (shared with the map)
//   bus          - requester bus (page_req_arb_if.slave)
//   pam_alloc/pam_free/pam_stat/pam_freeall - one-cycle command strobes
//   pam_pageno, pam_val - operands to the map, frozen from grant to ack
//   pam_result, pam_done - map result and done flag
//   dbg_state    - current sequencing state
// Build option PAGE_REQ_ARB_FREE_CHECK_EN: frees go out as pam_stat with
// pam_val=2'b00 (clear, return prior bit) and a prior 0 is flagged as a
// double free; pam_free is then never strobed.
module page_req_arb import page_req_pkg::*; #(
    parameter int NCLIENT = NCLIENT_DEFAULT,
    parameter int PGBITS  = PGBITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    page_req_arb_if.slave     bus,
    output logic              pam_alloc,
    output logic              pam_free,
    output logic              pam_stat,
    output logic              pam_freeall,
    output logic [PGBITS-1:0] pam_pageno,
    output logic [1:0]        pam_val,
    input  logic [PGBITS-1:0] pam_result,
    input  logic              pam_done,
    output state_t            dbg_state
);
    localparam int IDXW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    state_t             state;
    cmd_t               cmd_q;
    logic [NCLIENT-1:0] gnt_q;

    logic [NCLIENT-1:0] arb_grant;
    logic [IDXW-1:0]    arb_idx;
    logic               arb_any;
    logic               arb_advance;

    cmd_t               req_cmd;
    logic [PGBITS-1:0]  req_page;
    logic [1:0]         req_val;

    assign arb_advance = (state == ST_IDLE) && arb_any;
    assign dbg_state   = state;

    rr_arbiter #(.NCLIENT(NCLIENT)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Operands of the client being picked this cycle.
    always_comb begin
        req_cmd  = cmd_t'(bus.cmd[2*int'(arb_idx) +: 2]);
        req_page = bus.pageno_i[PGBITS*int'(arb_idx) +: PGBITS];
        req_val  = bus.val_i[2*int'(arb_idx) +: 2];
`ifdef PAGE_REQ_ARB_FREE_CHECK_EN
        // A checked free is a stat that clears the bit.
        if (req_cmd == CMD_FREE) begin
            req_val = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            cmd_q        <= CMD_ALLOC;
            gnt_q        <= '0;
            pam_alloc    <= 1'b0;
            pam_free     <= 1'b0;
            pam_stat     <= 1'b0;
            pam_freeall  <= 1'b0;
            pam_pageno   <= '0;
            pam_val      <= 2'b00;
            bus.ack      <= '0;
            bus.pageno_o <= '0;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    // The map runs its own clear pass after reset.
                    if (pam_done) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q      <= arb_grant;
                        cmd_q      <= req_cmd;
                        pam_pageno <= req_page;
                        pam_val    <= req_val;
                        bus.busy   <= 1'b1;
                        state      <= ST_ISSUE;
                        // Strobe registers are high exactly while in ISSUE.
                        case (req_cmd)
                            CMD_ALLOC: pam_alloc <= 1'b1;
`ifdef PAGE_REQ_ARB_FREE_CHECK_EN
                            CMD_FREE:  pam_stat  <= 1'b1;
`else
                            CMD_FREE:  pam_free  <= 1'b1;
`endif
                            CMD_STAT:  pam_stat  <= 1'b1;
                            default:   pam_freeall <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    pam_alloc   <= 1'b0;
                    pam_free    <= 1'b0;
                    pam_stat    <= 1'b0;
                    pam_freeall <= 1'b0;
                    state       <= ST_WLO;
                end
                ST_WLO: begin
                    if (!pam_done) begin
                        state <= ST_WHI;
                    end
                end
                ST_WHI: begin
                    if (pam_done) begin
                        bus.ack <= gnt_q;
                        state   <= ST_RESP;
                        case (cmd_q)
                            CMD_ALLOC: begin
                                // Page 0 is reserved, so it signals exhaustion.
                                bus.pageno_o <= pam_result;
                                bus.err      <= (pam_result == '0);
                            end
                            CMD_FREE: begin
                                bus.pageno_o <= pam_pageno;
`ifdef PAGE_REQ_ARB_FREE_CHECK_EN
                                bus.err      <= ~pam_result[0];
`else
                                bus.err      <= 1'b0;
`endif
                            end
                            CMD_STAT: begin
                                bus.pageno_o <= {{(PGBITS-1){1'b0}}, pam_result[0]};
                                bus.err      <= 1'b0;
                            end
                            default: begin
                                bus.pageno_o <= '0;
                                bus.err      <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    bus.ack      <= '0;
                    bus.pageno_o <= '0;
                    bus.err      <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end
endmodule
